cr_huf_comp_bit_packer: RTL

- Read-side consumer of the Huffman symbol FIFO (`cr_huf_comp_sm_fifo` output side).
- Pops variable-length code entries `{eof, len, code}` and packs them LSB-first (deflate bit order) into 64-bit output words.
- Output uses a valid/ready handshake; downstream is the compressed-stream formatter.
- At frame end, flushes the residual bits as a zero-padded final word tagged with a byte count.

---
 rtl/cr_huf_comp_pkg.sv | 29 ++
 rtl/cr_huf_comp_bit_packer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cr_huf_comp_pkg.sv
// Shared types for the Huffman compressor: symbol FIFO entry layout, bit-packer
// widths and the code-length mask helper.
package cr_huf_comp_pkg;

    localparam int HUF_CODE_W     = 32;
    localparam int HUF_LEN_W      = 6;
    localparam int HUF_PACK_OUT_W = 64;
    localparam int HUF_PACK_ACC_W = 96;

    typedef struct packed {
        logic                  eof;
        logic [HUF_LEN_W-1:0]  len;
        logic [HUF_CODE_W-1:0] code;
    } huf_sym_entry_t;

    // Symbol FIFO instances size their data path from this.
    localparam int HUF_SYM_ENTRY_W = $bits(huf_sym_entry_t);

    typedef enum logic {
        PK_FILL  = 1'b0,
        PK_FLUSH = 1'b1
    } pack_state_e;

    function automatic logic [HUF_CODE_W-1:0] huf_len_mask(input logic [HUF_LEN_W-1:0] len);
        if (len >= HUF_LEN_W'(HUF_CODE_W)) return '1;
        return (HUF_CODE_W'(1) << len) - HUF_CODE_W'(1);
    endfunction

endpackage

// File: rtl/cr_huf_comp_bit_packer.sv
// Packs variable-length Huffman codes LSB-first into OUT_W-bit words with a final
// zero-padded, byte-counted flush word. Optional statistics: CR_HUF_COMP_BIT_PACKER_STATS_EN.
module cr_huf_comp_bit_packer
    import cr_huf_comp_pkg::*;
#(
    parameter int CODE_W = HUF_CODE_W,
    parameter int LEN_W  = HUF_LEN_W,
    parameter int OUT_W  = HUF_PACK_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    fifo_empty,
    input  logic [LEN_W+CODE_W:0]   fifo_rdata,
    output logic                    fifo_ren,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_last,
    output logic [3:0]              out_bytes
`ifdef CR_HUF_COMP_BIT_PACKER_STATS_EN
    ,
    output logic [31:0]             stat_frame_bits,
    output logic [15:0]             stat_frames
`endif
);

    localparam int ACC_W  = OUT_W + CODE_W;
    localparam int BITS_W = $clog2(ACC_W + 1);
    localparam logic [BITS_W-1:0] OUT_W_B  = BITS_W'(OUT_W);
    localparam logic [LEN_W-1:0]  CODE_W_L = LEN_W'(CODE_W);
    localparam logic [3:0]        FULL_BYTES = 4'(OUT_W / 8);

    function automatic logic [LEN_W-1:0] len_sat(input logic [LEN_W-1:0] l);
        return (l > CODE_W_L) ? CODE_W_L : l;
    endfunction

    function automatic logic [CODE_W-1:0] len_mask(input logic [LEN_W-1:0] l);
        if (l >= CODE_W_L) return '1;
        return (CODE_W'(1) << l) - CODE_W'(1);
    endfunction

    logic                head_eof;
    logic [LEN_W-1:0]    head_len;
    logic [LEN_W-1:0]    len_eff;
    logic [CODE_W-1:0]   code_masked;

    pack_state_e         state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [BITS_W-1:0]   bits_q, bits_d;
    logic                held_q, held_d;
    logic                full;
    logic                pop;
    logic                last_hs;

    assign head_eof    = fifo_rdata[LEN_W+CODE_W];
    assign head_len    = fifo_rdata[LEN_W+CODE_W-1:CODE_W];
    assign len_eff     = len_sat(head_len);
    assign code_masked = fifo_rdata[CODE_W-1:0] & len_mask(head_len);
    assign full        = (bits_q >= OUT_W_B);
    assign out_data    = acc_q[OUT_W-1:0];
    assign fifo_ren    = pop;

    // A zero-length eof at the head is absorbed before a full word is offered,
    // so an exactly-full frame ends in one last word; never while a word is held.
    always_comb begin
        pop       = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_bytes = FULL_BYTES;
        last_hs   = 1'b0;
        state_d   = state_q;
        acc_d     = acc_q;
        bits_d    = bits_q;
        if (clear) begin
            state_d = PK_FILL;
            acc_d   = '0;
            bits_d  = '0;
        end else begin
            case (state_q)
                PK_FILL: begin
                    pop = !fifo_empty &&
                          (!full || (head_eof && head_len == '0 && !held_q));
                    out_valid = full && !pop;
                    if (pop) begin
                        acc_d  = acc_q | (ACC_W'(code_masked) << bits_q);
                        bits_d = bits_q + BITS_W'(len_eff);
                        if (head_eof) state_d = PK_FLUSH;
                    end else if (out_valid && out_ready) begin
                        acc_d  = acc_q >> OUT_W;
                        bits_d = bits_q - OUT_W_B;
                    end
                end
                PK_FLUSH: begin
                    out_valid = 1'b1;
                    out_last  = (bits_q <= OUT_W_B);
                    out_bytes = full ? FULL_BYTES : 4'((bits_q + BITS_W'(7)) >> 3);
                    if (out_ready) begin
                        if (out_last) begin
                            last_hs = 1'b1;
                            state_d = PK_FILL;
                            acc_d   = '0;
                            bits_d  = '0;
                        end else begin
                            acc_d  = acc_q >> OUT_W;
                            bits_d = bits_q - OUT_W_B;
                        end
                    end
                end
                default: state_d = PK_FILL;
            endcase
        end
    end

    assign held_d = (state_q == PK_FILL) && out_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PK_FILL;
            acc_q   <= '0;
            bits_q  <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            bits_q  <= bits_d;
            held_q  <= held_d;
        end
    end

`ifdef CR_HUF_COMP_BIT_PACKER_STATS_EN
    logic [31:0] stat_run_q;
    logic [31:0] stat_frame_bits_q;
    logic [15:0] stat_frames_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_run_q        <= '0;
            stat_frame_bits_q <= '0;
            stat_frames_q     <= '0;
        end else if (clear) begin
            stat_run_q <= '0;
        end else if (last_hs) begin
            stat_frame_bits_q <= stat_run_q;
            stat_run_q        <= '0;
            stat_frames_q     <= stat_frames_q + 16'd1;
        end else if (pop) begin
            stat_run_q <= stat_run_q + 32'(len_eff);
        end
    end

    assign stat_frame_bits = stat_frame_bits_q;
    assign stat_frames     = stat_frames_q;
`endif

`ifndef SYNTHESIS
    len_legal_a: assert property (@(posedge clk) disable iff (!rst_n)
                                  fifo_ren |-> (head_len <= CODE_W_L))
        else $error("cr_huf_comp_bit_packer: code length %0d exceeds CODE_W", head_len);
`endif

endmodule
